// File: rtl/snd_dma_pkg.sv
// Shared definitions for the sound DMA address generator: register map,
// FSM encoding, byte-field widths and the address-to-byte read helper.
package snd_dma_pkg;

   localparam logic [3:0] IDX_CTRL      = 4'd0;
   localparam logic [3:0] IDX_START_HI  = 4'd1;
   localparam logic [3:0] IDX_START_MID = 4'd2;
   localparam logic [3:0] IDX_START_LO  = 4'd3;
   localparam logic [3:0] IDX_CNT_HI    = 4'd4;
   localparam logic [3:0] IDX_CNT_MID   = 4'd5;
   localparam logic [3:0] IDX_CNT_LO    = 4'd6;
   localparam logic [3:0] IDX_END_HI    = 4'd7;
   localparam logic [3:0] IDX_END_MID   = 4'd8;
   localparam logic [3:0] IDX_END_LO    = 4'd9;

   localparam int HI_W  = 6;
   localparam int MID_W = 8;
   localparam int LO_W  = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      BYTE_HI   = 2'd0,
      BYTE_MID  = 2'd1,
      BYTE_LO   = 2'd2,
      BYTE_NONE = 2'd3
   } byte_sel_t;

   // Word address [21:1] as seen through the odd-byte bus registers.
   function automatic logic [7:0] addr_byte(input logic [21:1] a, input byte_sel_t sel);
      logic [7:0] b;
      b = 8'h00;
      case (sel)
         BYTE_HI:  b = {{(8-HI_W){1'b0}}, a[21:16]};
         BYTE_MID: b = a[15:8];
         BYTE_LO:  b = {a[7:1], 1'b0};
         default:  b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/snd_addr_reg.sv
// Byte-writable shadow copy of one frame address, with its own byte read mux.
module snd_addr_reg
   import snd_dma_pkg::*;
#(
   parameter int             AW       = 21,
   parameter logic [AW:1]    RST_ADDR = '0
) (
   input  logic          clk32,
   input  logic          porb,
   input  logic          we_hi,
   input  logic          we_mid,
   input  logic          we_lo,
   input  logic [7:0]    din,
   input  logic [1:0]    rd_sel,
   output logic [7:0]    dout,
   output logic [AW:1]   q
);

   logic [AW:1] r_q;

   always_ff @(posedge clk32 or negedge porb) begin
      if (!porb) begin
         r_q <= RST_ADDR;
      end else begin
         if (we_hi)  r_q[AW:16] <= din[AW-16:0];
         if (we_mid) r_q[15:8]  <= din;
         // Byte address bit 0 has no storage; only din[7:1] lands.
         if (we_lo)  r_q[7:1]   <= din[7:1];
      end
   end

   assign q    = r_q;
   assign dout = addr_byte(r_q, byte_sel_t'(rd_sel));

endmodule

// File: rtl/snd_dma_addr.sv
// Sound DMA address generator: double-buffered frame start/end, running word
// counter and the IDLE/START/RUN sequencer feeding the MCU control stage.
module snd_dma_addr
   import snd_dma_pkg::*;
#(
   parameter int             AW       = 21,
   parameter logic [AW:1]    RST_ADDR = '0
) (
   input  logic          clk32,
   input  logic          porb,
   input  logic          resb,
   input  logic [3:0]    reg_idx,
   input  logic [7:0]    reg_din,
   input  logic          reg_we,
   output logic [7:0]    reg_dout,
   input  logic          snd_adv,
   input  logic          frame_rep,
   input  logic          frame_stop,
   output logic [AW:1]   snd,
   output logic [AW:1]   sft,
   output logic          sndon,
   output logic          sfrep,
   output logic          frame_done
);

   state_t        r_state, w_state_nxt;
   logic [AW:1]   r_snd, w_snd_nxt;
   logic [AW:1]   r_sft, w_sft_nxt;
   logic          r_sndon, w_sndon_nxt;
   logic          r_sfrep, w_sfrep_nxt;
   logic          r_frame_done, w_fd_nxt;

   logic          w_ctrl_we;
   byte_sel_t     w_sel;
   logic [AW:1]   w_sst_sh, w_sft_sh;
   logic [7:0]    w_start_dout, w_end_dout;

   assign w_ctrl_we = reg_we && (reg_idx == IDX_CTRL);

   always_comb begin
      w_sel = BYTE_NONE;
      case (reg_idx)
         IDX_START_HI,  IDX_CNT_HI,  IDX_END_HI:  w_sel = BYTE_HI;
         IDX_START_MID, IDX_CNT_MID, IDX_END_MID: w_sel = BYTE_MID;
         IDX_START_LO,  IDX_CNT_LO,  IDX_END_LO:  w_sel = BYTE_LO;
         default:                                 w_sel = BYTE_NONE;
      endcase
   end

   snd_addr_reg #(.AW(AW), .RST_ADDR(RST_ADDR)) u_start (
      .clk32  (clk32),
      .porb   (porb),
      .we_hi  (reg_we && (reg_idx == IDX_START_HI)),
      .we_mid (reg_we && (reg_idx == IDX_START_MID)),
      .we_lo  (reg_we && (reg_idx == IDX_START_LO)),
      .din    (reg_din),
      .rd_sel (w_sel),
      .dout   (w_start_dout),
      .q      (w_sst_sh)
   );

   snd_addr_reg #(.AW(AW), .RST_ADDR(RST_ADDR)) u_end (
      .clk32  (clk32),
      .porb   (porb),
      .we_hi  (reg_we && (reg_idx == IDX_END_HI)),
      .we_mid (reg_we && (reg_idx == IDX_END_MID)),
      .we_lo  (reg_we && (reg_idx == IDX_END_LO)),
      .din    (reg_din),
      .rd_sel (w_sel),
      .dout   (w_end_dout),
      .q      (w_sft_sh)
   );

   always_comb begin
      reg_dout = 8'h00;
      case (reg_idx)
         IDX_CTRL:                                 reg_dout = {6'b0, r_sfrep, r_sndon};
         IDX_START_HI, IDX_START_MID, IDX_START_LO: reg_dout = w_start_dout;
         IDX_CNT_HI,   IDX_CNT_MID,   IDX_CNT_LO:   reg_dout = addr_byte(r_snd, w_sel);
         IDX_END_HI,   IDX_END_MID,   IDX_END_LO:   reg_dout = w_end_dout;
         default:                                  reg_dout = 8'h00;
      endcase
   end

   // The frame start is latched straight into the counter on reload; nothing
   // else consumes a working copy of it, so only the end address is held.
   always_comb begin
      w_state_nxt = r_state;
      w_snd_nxt   = r_snd;
      w_sft_nxt   = r_sft;
      w_sndon_nxt = r_sndon;
      w_sfrep_nxt = r_sfrep;
      w_fd_nxt    = 1'b0;
      if (!resb) begin
         w_state_nxt = ST_IDLE;
         w_sndon_nxt = 1'b0;
         w_sfrep_nxt = 1'b0;
      end else begin
         if (w_ctrl_we) w_sfrep_nxt = reg_din[1];
         case (r_state)
            ST_IDLE: begin
               if (w_ctrl_we && reg_din[0]) begin
                  w_sndon_nxt = 1'b1;
                  w_state_nxt = ST_START;
               end
            end
            ST_START: begin
               if (w_ctrl_we && !reg_din[0]) begin
                  w_sndon_nxt = 1'b0;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_snd_nxt   = w_sst_sh;
                  w_sft_nxt   = w_sft_sh;
                  w_state_nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               if (frame_stop) begin
                  w_sndon_nxt = 1'b0;
                  w_state_nxt = ST_IDLE;
                  w_fd_nxt    = 1'b1;
               end else if (w_ctrl_we && !reg_din[0]) begin
                  w_sndon_nxt = 1'b0;
                  w_state_nxt = ST_IDLE;
               end else if (frame_rep) begin
                  w_snd_nxt = w_sst_sh;
                  w_sft_nxt = w_sft_sh;
                  w_fd_nxt  = 1'b1;
               end else if (snd_adv) begin
                  w_snd_nxt = r_snd + 1'b1;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk32 or negedge porb) begin
      if (!porb) begin
         r_state      <= ST_IDLE;
         r_snd        <= RST_ADDR;
         r_sft        <= RST_ADDR;
         r_sndon      <= 1'b0;
         r_sfrep      <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_snd        <= w_snd_nxt;
         r_sft        <= w_sft_nxt;
         r_sndon      <= w_sndon_nxt;
         r_sfrep      <= w_sfrep_nxt;
         r_frame_done <= w_fd_nxt;
      end
   end

   assign snd        = r_snd;
   assign sft        = r_sft;
   assign sndon      = r_sndon;
   assign sfrep      = r_sfrep;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_snd_dma_addr.sv
// Scoreboard bench for snd_dma_addr: stimulus queues expected values, a
// negedge monitor compares probes and every frame_done pulse against them.
module tb_snd_dma_addr;

   localparam int SIG_SND   = 0;
   localparam int SIG_SFT   = 1;
   localparam int SIG_SNDON = 2;
   localparam int SIG_SFREP = 3;
   localparam int SIG_DOUT  = 4;
   localparam int SIG_FD    = 5;

   typedef struct {
      int          sig;
      logic [31:0] val;
      string       name;
   } probe_t;

   typedef struct {
      logic [20:0] snd;
      logic [20:0] sft;
      logic        sndon;
      string       name;
   } frame_t;

   probe_t pq[$];
   frame_t fq[$];
   int errors = 0;
   int checks = 0;

   logic        clk32 = 1'b0;
   logic        porb = 1'b0;
   logic        resb = 1'b1;
   logic [3:0]  reg_idx = 4'd0;
   logic [7:0]  reg_din = 8'h00;
   logic        reg_we = 1'b0;
   logic        snd_adv = 1'b0;
   logic        frame_rep = 1'b0;
   logic        frame_stop = 1'b0;
   logic [7:0]  reg_dout;
   logic [21:1] snd;
   logic [21:1] sft;
   logic        sndon;
   logic        sfrep;
   logic        frame_done;

   snd_dma_addr dut (
      .clk32      (clk32),
      .porb       (porb),
      .resb       (resb),
      .reg_idx    (reg_idx),
      .reg_din    (reg_din),
      .reg_we     (reg_we),
      .reg_dout   (reg_dout),
      .snd_adv    (snd_adv),
      .frame_rep  (frame_rep),
      .frame_stop (frame_stop),
      .snd        (snd),
      .sft        (sft),
      .sndon      (sndon),
      .sfrep      (sfrep),
      .frame_done (frame_done)
   );

   always #5 clk32 = ~clk32;

   function automatic logic [31:0] actual_of(input int sig);
      logic [31:0] v;
      v = 32'h0;
      case (sig)
         SIG_SND:   v = {11'h0, snd};
         SIG_SFT:   v = {11'h0, sft};
         SIG_SNDON: v = {31'h0, sndon};
         SIG_SFREP: v = {31'h0, sfrep};
         SIG_DOUT:  v = {24'h0, reg_dout};
         SIG_FD:    v = {31'h0, frame_done};
         default:   v = 32'hDEAD_BEEF;
      endcase
      return v;
   endfunction

   always @(negedge clk32) begin
      probe_t p;
      frame_t f;
      while (pq.size() != 0) begin
         p = pq.pop_front();
         checks++;
         if (actual_of(p.sig) !== p.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", p.name, actual_of(p.sig), p.val);
         end
      end
      if (frame_done !== 1'b0) begin
         checks++;
         if (fq.size() == 0) begin
            errors++;
            $display("FAIL frame_done_unexpected: got %b expected 0 (snd=%h)", frame_done, snd);
         end else begin
            f = fq.pop_front();
            if (snd !== f.snd || sft !== f.sft || sndon !== f.sndon) begin
               errors++;
               $display("FAIL %s: got snd=%h sft=%h sndon=%b expected snd=%h sft=%h sndon=%b",
                        f.name, snd, sft, sndon, f.snd, f.sft, f.sndon);
            end
         end
      end
   end

   task automatic exp_sig(input int sig, input logic [31:0] v, input string n);
      probe_t p;
      p.sig = sig; p.val = v; p.name = n;
      pq.push_back(p);
   endtask

   task automatic exp_frame(input logic [20:0] s, input logic [20:0] e, input logic on, input string n);
      frame_t f;
      f.snd = s; f.sft = e; f.sndon = on; f.name = n;
      fq.push_back(f);
   endtask

   task automatic tick();
      @(posedge clk32);
      #1;
   endtask

   task automatic settle();
      @(negedge clk32);
      #1;
   endtask

   task automatic wr(input logic [3:0] idx, input logic [7:0] d);
      reg_idx = idx; reg_din = d; reg_we = 1'b1;
      tick();
      reg_we = 1'b0;
   endtask

   task automatic rd(input logic [3:0] idx, input logic [7:0] v, input string n);
      reg_idx = idx;
      exp_sig(SIG_DOUT, {24'h0, v}, n);
      settle();
   endtask

   task automatic pulse_adv();
      snd_adv = 1'b1;
      tick();
      snd_adv = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // power-on reset state
      exp_sig(SIG_SND, 0, "rst_snd");
      exp_sig(SIG_SFT, 0, "rst_sft");
      exp_sig(SIG_SNDON, 0, "rst_sndon");
      exp_sig(SIG_SFREP, 0, "rst_sfrep");
      exp_sig(SIG_FD, 0, "rst_frame_done");
      exp_sig(SIG_DOUT, 0, "rst_ctrl_rd");
      settle();
      porb = 1'b1;

      // load and start: byte 0x012344 -> word 0x091A2, byte 0x012400 -> 0x09200
      wr(4'd1, 8'h01); wr(4'd2, 8'h23); wr(4'd3, 8'h44);
      wr(4'd7, 8'h01); wr(4'd8, 8'h24); wr(4'd9, 8'h00);
      rd(4'd3, 8'h44, "start_lo_rb");
      rd(4'd8, 8'h24, "end_mid_rb");
      rd(4'd12, 8'h00, "unmapped_rd");
      wr(4'd0, 8'h01);
      exp_sig(SIG_SNDON, 1, "sndon_rise");
      exp_sig(SIG_SND, 0, "snd_before_start");
      settle();
      tick();
      exp_sig(SIG_SND, 32'h091A2, "start_snd");
      exp_sig(SIG_SFT, 32'h09200, "start_sft");
      settle();

      // advance and counter readback (byte 0x012346)
      pulse_adv();
      exp_sig(SIG_SND, 32'h091A3, "adv_snd");
      rd(4'd6, 8'h46, "cnt_lo_rd");
      rd(4'd5, 8'h23, "cnt_mid_rd");
      rd(4'd4, 8'h01, "cnt_hi_rd");

      // shadow writes do not disturb the running frame
      wr(4'd3, 8'h80);
      wr(4'd9, 8'h10);
      exp_sig(SIG_SND, 32'h091A3, "snd_no_reload");
      exp_sig(SIG_SFT, 32'h09200, "sft_buffered");
      rd(4'd3, 8'h80, "start_lo_shadow_rb");

      // frame_rep with coincident snd_adv: reload wins, adv dropped
      exp_frame(21'h091C0, 21'h09208, 1'b1, "rep_reload");
      frame_rep = 1'b1; snd_adv = 1'b1;
      tick();
      frame_rep = 1'b0; snd_adv = 1'b0;
      settle();
      exp_sig(SIG_SND, 32'h091C0, "snd_after_rep");
      exp_sig(SIG_FD, 0, "frame_done_one_cycle");
      settle();

      // start-mid write coincident with reload: old shadow used
      exp_frame(21'h091C0, 21'h09208, 1'b1, "rep_coincident_write");
      reg_idx = 4'd2; reg_din = 8'h30; reg_we = 1'b1; frame_rep = 1'b1;
      tick();
      reg_we = 1'b0; frame_rep = 1'b0;
      rd(4'd2, 8'h30, "start_mid_new_rb");
      exp_frame(21'h09840, 21'h09208, 1'b1, "rep_new_mid");
      frame_rep = 1'b1;
      tick();
      frame_rep = 1'b0;
      settle();

      // wrap: start byte 0x3FFFFE -> word 0x1FFFFF
      wr(4'd1, 8'h3F); wr(4'd2, 8'hFF); wr(4'd3, 8'hFE);
      exp_frame(21'h1FFFFF, 21'h09208, 1'b1, "rep_wrap_start");
      frame_rep = 1'b1;
      tick();
      frame_rep = 1'b0;
      pulse_adv();
      exp_sig(SIG_SND, 0, "wrap_snd");
      rd(4'd4, 8'h00, "wrap_cnt_hi");
      rd(4'd5, 8'h00, "wrap_cnt_mid");
      rd(4'd6, 8'h00, "wrap_cnt_lo");
      pulse_adv();
      exp_sig(SIG_SND, 1, "post_wrap_snd");
      rd(4'd6, 8'h02, "post_wrap_cnt_lo");

      // ctrl write with bit0=1 while running: sfrep updates, no reload
      wr(4'd0, 8'h03);
      exp_sig(SIG_SFREP, 1, "sfrep_set");
      exp_sig(SIG_SND, 1, "ctrl_no_reload");
      rd(4'd0, 8'h03, "ctrl_rd_run");

      // stop with coincident adv
      exp_frame(21'h000001, 21'h09208, 1'b0, "stop");
      frame_stop = 1'b1; snd_adv = 1'b1;
      tick();
      frame_stop = 1'b0; snd_adv = 1'b0;
      pulse_adv();
      exp_sig(SIG_SND, 1, "adv_ignored_idle");
      rd(4'd0, 8'h02, "ctrl_rd_stopped");
      frame_rep = 1'b1;
      tick();
      frame_rep = 1'b0;
      exp_sig(SIG_SND, 1, "rep_ignored_idle");
      settle();

      // restart, then ctrl clear coincident with frame_rep: no frame_done
      wr(4'd0, 8'h01);
      tick();
      exp_sig(SIG_SND, 32'h1FFFFF, "restart_snd");
      exp_sig(SIG_SFT, 32'h09208, "restart_sft");
      settle();
      reg_idx = 4'd0; reg_din = 8'h00; reg_we = 1'b1; frame_rep = 1'b1;
      tick();
      reg_we = 1'b0; frame_rep = 1'b0;
      exp_sig(SIG_SNDON, 0, "ctrl_clear");
      exp_sig(SIG_SND, 32'h1FFFFF, "ctrl_clear_snd");
      settle();

      // soft reset mid-run
      wr(4'd0, 8'h03);
      tick();
      pulse_adv();
      pulse_adv();
      exp_sig(SIG_SND, 1, "pre_resb_snd");
      settle();
      resb = 1'b0;
      tick();
      resb = 1'b1;
      exp_sig(SIG_SNDON, 0, "resb_sndon");
      exp_sig(SIG_SFREP, 0, "resb_sfrep");
      exp_sig(SIG_SND, 1, "resb_snd_kept");
      rd(4'd3, 8'hFE, "resb_shadow_kept");
      pulse_adv();
      exp_sig(SIG_SND, 1, "resb_idle_adv_ignored");
      settle();

      // async power-on reset between clock edges
      wr(4'd0, 8'h01);
      reg_idx = 4'd1;
      #1;
      porb = 1'b0;
      exp_sig(SIG_SND, 0, "porb_snd");
      exp_sig(SIG_SFT, 0, "porb_sft");
      exp_sig(SIG_SNDON, 0, "porb_sndon");
      exp_sig(SIG_SFREP, 0, "porb_sfrep");
      exp_sig(SIG_DOUT, 0, "porb_start_hi");
      settle();
      porb = 1'b1;
      settle();

      checks++;
      if (fq.size() != 0) begin
         errors++;
         $display("FAIL frame_done_missing: got %0d pending expected 0", fq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/snd_dma_addr.md
Name: snd_dma_addr

Overview:
Sound DMA address generator for the GSTMCU. It sits directly upstream of the MCU control stage. It holds the bus-visible frame start and frame end registers, and drives the running sound address `snd[21:1]` and the frame end `sft[21:1]` that the control stage compares. It reacts to the frame-repeat and frame-stop events that stage reports back, and it owns the `sndon`/`sfrep` control bits.

Parameters:
AW, 21, top word-address bit; address buses are [AW:1]
RST_ADDR, 0, reset value of every address register

Ports:
clk32  in  1  system clock; all state changes on its rising edge
porb  in  1  asynchronous active-low reset
resb  in  1  synchronous active-low soft reset (bus RESET)
reg_idx  in  4  register index within $FF8900 block (0..9, see Behaviour)
reg_din  in  8  odd-byte write data
reg_we  in  1  one-cycle write strobe
reg_dout  out  8  combinational read data for reg_idx
snd_adv  in  1  one-cycle pulse: one sound word fetched, advance address
frame_rep  in  1  one-cycle pulse: frame end reached with repeat set
frame_stop  in  1  one-cycle pulse: frame end reached without repeat
snd  out  21  current sound DMA word address [AW:1]
sft  out  21  active frame end address [AW:1]
sndon  out  1  sound DMA enable
sfrep  out  1  frame repeat enable
frame_done  out  1  one-cycle pulse at every frame end (repeat or stop)

Behaviour:
- Clocking and reset:
  - Single clock `clk32`; `porb` is asynchronous and active-low.
  - While `porb`=0: all registers = `RST_ADDR`/0, state IDLE, `sndon`=`sfrep`=`frame_done`=0.
- Register map (`reg_idx`):
  - 0 ctrl: {6'b0, `sfrep`, `sndon`}.
  - 1/2/3 start hi/mid/lo.
  - 4/5/6 counter hi/mid/lo (read-only).
  - 7/8/9 end hi/mid/lo.
  - Indices 10..15: read 0; writes ignored.
- Byte packing:
  - hi = `addr[21:16]` in `din[5:0]`.
  - mid = `addr[15:8]`.
  - lo = `addr[7:1]` in `din[7:1]`; `din[0]` ignored.
  - Reads return unused bits as 0.
- Double buffering:
  - Bus writes go to shadow registers `sst_sh` and `sft_sh`.
  - Working `sst`/`sft` load only at frame start (START state or `frame_rep`).
  - Start and end read back from the shadow registers.
- State machine:
  - IDLE: writing ctrl with bit0=1 sets `sndon`=1 and moves to START on the same edge.
  - START (exactly one cycle): `sst`<=`sst_sh`, `sft`<=`sft_sh`, `snd`<=`sst_sh`; go to RUN.
  - RUN, on `snd_adv`: `snd`<=`snd`+1, modulo 2^21 (0x1FFFFF wraps to 0).
  - RUN, on `frame_rep`: reload as in START; pulse `frame_done`; stay in RUN.
  - RUN, on `frame_stop`: `sndon`<=0, go to IDLE, `snd` holds its value, pulse `frame_done`.
  - RUN, ctrl write with bit0=0: `sndon`<=0, go to IDLE immediately, no `frame_done`.
  - Ctrl write with bit0=1 while in START or RUN: no reload. `sfrep` updates on every ctrl write.
- Priority within one cycle: `porb` > `resb` > `frame_stop` > ctrl write clearing `sndon` > `frame_rep` > `snd_adv`.
  - `snd_adv` coincident with a reload is dropped.
  - `snd_adv`, `frame_rep` and `frame_stop` are ignored in IDLE and START.
- Write coinciding with reload: the reload uses the shadow value from before the write; the new byte applies at the next frame.
- `resb`=0 (synchronous): `sndon`=`sfrep`=0, state IDLE. Shadow, working and `snd` registers are retained.
- Latency:
  - `sndon` rises 1 edge after the ctrl write.
  - `snd` is valid 2 edges after the ctrl write.
  - `frame_done` is registered: it goes high on the edge that samples the event.

Decomposition:
- Package `snd_dma_pkg`:
  - register-index localparams (IDX_CTRL..IDX_END_LO);
  - state encoding (IDLE, START, RUN);
  - byte-field width constants.
- Sub-module `snd_addr_reg`: a 21-bit byte-addressable shadow register with hi/mid/lo write enables and a byte read mux. Instantiate twice (start, end).
- Counter, working registers and FSM stay in the top module.

Test Plan:
- Load and start:
  - Stimulus: write start 0x01/0x23/0x44, end 0x01/0x24/0x00, ctrl=0x01.
  - Response: `sndon`=1 after 1 edge; after 2 edges `snd`=0x091A2 (word address), `sft`=0x09200.
- Advance and wrap:
  - Stimulus: start=0x3F/0xFF/0xFE, run, 2 `snd_adv` pulses.
  - Response: `snd` 0x1FFFFF then 0x000000; counter read hi/mid/lo = 0x00/0x00/0x00.
- Repeat with buffering:
  - Stimulus: while running, write new start lo; then `frame_rep` pulse.
  - Response: `snd`, `sst` and `sft` reload from the new shadow values; `frame_done` high for exactly 1 cycle.
- Stop:
  - Stimulus: `frame_stop` together with `snd_adv` in the same cycle.
  - Response: `sndon`=0, `snd` unchanged, `frame_done` pulse; a following `snd_adv` is ignored.
- Coincident write and reload:
  - Stimulus: write start mid in the same cycle as `frame_rep`.
  - Response: `snd` takes the old shadow value; start-mid readback shows the new byte.
- Resets:
  - Stimulus: `resb`=0 for 1 cycle mid-RUN.
  - Response: `sndon`=`sfrep`=0, `snd` retained.
  - Stimulus: `porb` pulse asynchronous to `clk32`.
  - Response: all outputs 0 immediately.
